debounce_bank: RTL and testbench

Parametrised multi-channel push-button/switch debouncer: N_CH asynchronous inputs are synchronised and filtered against a shared prescaled tick. Each channel produces a clean level plus single-cycle rise/fall event pulses and an optional long-press pulse. The block sits between board-level buttons/switches and the picoversat peripheral/register layer, replacing single-channel, press-only debouncers.

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/debounce_ch.sv | 103 ++++++++++
 rtl/debounce_bank.sv | 65 ++++++
 tb/tb_debounce_bank.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: default parameter values and the counter-width helpers shared by
// debounce_bank and debounce_ch (optional long-press logic: DEBOUNCE_LONGPRESS_EN).
package debounce_pkg;

    localparam int DEF_N_CH         = 4;
    localparam int DEF_TICK_DIV     = 250000;
    localparam int DEF_STABLE_TICKS = 4;
    localparam int DEF_LONG_TICKS   = 400;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // A counter that must hold 0..max_val is always sized from max_val, never by hand.
    function automatic int cnt_w(input int max_val);
        return (clog2(max_val + 1) < 1) ? 1 : clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one channel - 2-flop synchroniser, tick-driven stability filter,
// rise/fall pulses and, with DEBOUNCE_LONGPRESS_EN, a saturating hold counter.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_in,
    output logic lvl,
    output logic rise,
    output logic fall,
    output logic long_p
);

    localparam int SW = cnt_w(STABLE_TICKS);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);

    logic [1:0]    sync_q, sync_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[0], btn_in};
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync_q[1] == lvl_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == STABLE_LAST) begin
                lvl_d  = sync_q[1];
                cnt_d  = '0;
                rise_d = sync_q[1];
                fall_d = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign lvl  = lvl_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int LW = cnt_w(LONG_TICKS);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_TICKS);

    logic [LW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Saturation at LONG_MAX is what stops a repeat pulse until release.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!lvl_q) begin
            hold_d = '0;
        end else if (tick && (hold_q != LONG_MAX)) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_d == LONG_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_p = long_q;
`else
    // Constant 0; LONG_TICKS stays referenced so both builds share one parameter list.
    assign long_p = 1'b0 && (LONG_TICKS > 0);
`endif

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH debounced channels sharing one sample-tick prescaler, plus a
// registered any_evt summary. Long-press pulses exist only with DEBOUNCE_LONGPRESS_EN.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_lvl,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_long,
    output logic            any_evt
);

    localparam int PW = cnt_w(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;
    logic          any_evt_q, any_evt_d;

    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .btn_in (btn_in[i]),
            .lvl    (btn_lvl[i]),
            .rise   (btn_rise[i]),
            .fall   (btn_fall[i]),
            .long_p (btn_long[i])
        );
    end

    always_comb begin
        any_evt_d = |{btn_rise, btn_fall, btn_long};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            any_evt_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            any_evt_q <= any_evt_d;
        end
    end

    assign any_evt = any_evt_q;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed scenarios plus randomized bouncing inputs, checked every
// cycle against an event-level reference model of the debouncer.
`timescale 1ns/1ps
module tb_debounce_bank;

    localparam int N_CH         = 4;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;
    localparam int LONG_TICKS   = 8;
`ifdef DEBOUNCE_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] btn_in = '0;
    logic [N_CH-1:0] btn_lvl, btn_rise, btn_fall, btn_long;
    logic            any_evt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .N_CH         (N_CH),
        .TICK_DIV     (TICK_DIV),
        .STABLE_TICKS (STABLE_TICKS),
        .LONG_TICKS   (LONG_TICKS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .btn_lvl  (btn_lvl),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .btn_long (btn_long),
        .any_evt  (any_evt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: input seen 2 clocks late, a new level is accepted after
    // STABLE_TICKS sample ticks of uninterrupted disagreement, long press after
    // LONG_TICKS ticks spent at level 1.
    logic [N_CH-1:0] m_seen0, m_seen1;
    logic [N_CH-1:0] m_lvl, m_rise, m_fall, m_long;
    logic            m_any;
    int              m_cyc;
    int              m_mis  [N_CH];
    int              m_held [N_CH];

    task automatic model_clear();
        m_seen0 = '0; m_seen1 = '0;
        m_lvl = '0; m_rise = '0; m_fall = '0; m_long = '0; m_any = 1'b0;
        m_cyc = 0;
        for (int c = 0; c < N_CH; c++) begin
            m_mis[c]  = 0;
            m_held[c] = 0;
        end
    endtask

    task automatic model_step();
        bit tk;
        tk = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
        m_any = |{m_rise, m_fall, m_long};
        for (int c = 0; c < N_CH; c++) begin
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            m_long[c] = 1'b0;
            if (m_lvl[c]) begin
                if (tk) m_held[c]++;
                m_long[c] = LONG_EN && tk && (m_held[c] == LONG_TICKS);
            end else begin
                m_held[c] = 0;
            end
            if (m_seen1[c] == m_lvl[c]) begin
                m_mis[c] = 0;
            end else if (tk) begin
                m_mis[c]++;
                if (m_mis[c] == STABLE_TICKS) begin
                    m_lvl[c]  = m_seen1[c];
                    m_mis[c]  = 0;
                    m_rise[c] = m_seen1[c];
                    m_fall[c] = ~m_seen1[c];
                end
            end
        end
        m_seen1 = m_seen0;
        m_seen0 = btn_in;
        m_cyc++;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_clear();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("lvl",  btn_lvl,  m_lvl);
            check("rise", btn_rise, m_rise);
            check("fall", btn_fall, m_fall);
            check("long", btn_long, m_long);
            check("any_evt", any_evt, m_any);
            check("rise_and_fall", btn_rise & btn_fall, '0);
        end
    end

    // One stimulus slot: just after a rising edge, outputs already settled.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int first_lvl, first_any, rise_at, rise_n, long_at, long_n, fall_n, other_n;

    initial begin
        // Reset with all inputs high
        rst_n  = 1'b0;
        btn_in = '1;
        repeat (3) step();
        check("reset_outputs", {btn_lvl, btn_rise, btn_fall, btn_long, any_evt}, '0);
        rst_n = 1'b1;
        first_lvl = -1; first_any = -1; rise_at = -1; rise_n = 0; long_at = -1; long_n = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (first_lvl < 0 && btn_lvl == 4'hF) first_lvl = k;
            if (btn_rise != '0) begin rise_n++; rise_at = k; end
            if (first_any < 0 && any_evt) first_any = k;
            if (btn_long != '0) begin long_n++; if (long_at < 0) long_at = k; end
        end
        check("first_lvl_cycle", first_lvl, 12);
        check("rise_cycle", rise_at, 12);
        check("rise_pulse_count", rise_n, 1);
        check("any_evt_cycle", first_any, 13);
        check("long_cycle", long_at, LONG_EN ? 44 : -1);
        check("long_pulse_count", long_n, LONG_EN ? 1 : 0);

        // Release everything, re-press ch1 only: long press fires again
        btn_in = '0;
        repeat (30) step();
        btn_in = 4'h2;
        long_n = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (btn_long[1]) long_n++;
        end
        check("repress_long_count", long_n, LONG_EN ? 1 : 0);

        // Bounce on ch0 every 3 cycles, then a final rising edge
        btn_in = '0;
        repeat (30) step();
        rise_n = 0;
        for (int t = 0; t < 14; t++) begin
            btn_in[0] = (t % 2 == 0);
            repeat (3) begin
                step();
                if (btn_rise[0]) rise_n++;
            end
        end
        check("bounce_no_rise", rise_n, 0);
        btn_in[0] = 1'b1;
        rise_at = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (btn_rise[0] && rise_at < 0) rise_at = k;
        end
        check("bounce_final_rise_in_window", (rise_at >= 11 && rise_at <= 14), 1);

        // ch2 release, others untouched
        btn_in = 4'hF;
        repeat (20) step();
        btn_in = 4'hB;
        fall_n = 0; other_n = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (btn_fall[2]) fall_n++;
            other_n += $countones((btn_rise | btn_fall) & 4'hB);
        end
        check("ch2_fall_count", fall_n, 1);
        check("ch2_others_quiet", other_n, 0);
        check("ch2_lvl_after", btn_lvl, 4'hB);

        // Reset while ch3 is being filtered
        btn_in = 4'h3;
        repeat (20) step();
        btn_in = 4'hB;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {btn_lvl, btn_rise, btn_fall, btn_long, any_evt}, '0);
        step();
        rst_n = 1'b1;
        first_lvl = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (first_lvl < 0 && btn_lvl[3]) first_lvl = k;
        end
        check("midreset_ch3_latency", first_lvl, 12);

        // Randomized bouncing with occasional resets
        for (int k = 0; k < 3000; k++) begin
            step();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 13) == 0) btn_in[c] = ~btn_in[c];
            end
        end
        rst_n = 1'b1;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
